// File: rtl/task_4_playback_pkg.sv
// Shared types and constants for the task_4 playback buffer.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package task_4_playback_pkg;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry 0 sits in the least significant slot.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/task_4_playback_hex_to_7seg.sv
// Nibble to active-low seven-segment glyph, 0-F.
// Purely combinational lookup into the shared table.
module hex_to_7seg
  import task_4_playback_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/task_4_playback.sv
// Playback buffer: stores recorder bytes and replays them on
// LEDs and hex digits, stepped by key press or by a tick timer.
module task_4_playback
  import task_4_playback_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter int TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       key0_rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       key1_step,
  input  logic       key2_auto,
  input  logic       sw8,
  output logic [7:0] ledr,
  output logic [7:0] ledg,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3
);

  localparam int CW = AW + 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic [TW-1:0] tick;
  state_t        state;

  logic k1_s1, k1_s2, k1_s3;
  logic k2_s1, k2_s2, k2_s3;

  logic          step_ev;
  logic          auto_ev;
  logic          do_wr;
  logic          has_data;
  logic          at_end;
  logic          tick_hit;
  logic [AW-1:0] rptr_adv;
  logic [7:0]    rd;
  logic [7:0]    therm;
  logic [6:0]    seg_lo, seg_hi, seg_ptr, seg_cnt;

  assign step_ev  = k1_s3 & ~k1_s2;
  assign auto_ev  = k2_s3 & ~k2_s2;
  assign has_data = count != '0;
  assign do_wr    = wr_en && (count < CW'(DEPTH));
  assign at_end   = CW'(rptr) == count - CW'(1);
  assign tick_hit = tick == TW'(TICK_DIV - 1);
  assign rd       = mem[rptr];

  // Wrap to entry 0 only in loop mode; otherwise park on the last entry.
  always_comb begin
    rptr_adv = rptr + AW'(1);
    if (at_end)
      rptr_adv = sw8 ? '0 : rptr;
  end

  always_comb begin
    therm = '0;
    for (int i = 0; i < 8; i++)
      therm[i] = int'(count) > i;
  end

  hex_to_7seg u_lo  (.nib(rd[3:0]),   .seg(seg_lo));
  hex_to_7seg u_hi  (.nib(rd[7:4]),   .seg(seg_hi));
  hex_to_7seg u_ptr (.nib(4'(rptr)),  .seg(seg_ptr));
  hex_to_7seg u_cnt (.nib(4'(count)), .seg(seg_cnt));

  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge key0_rst) begin
    if (!key0_rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      tick  <= '0;
      state <= ST_MANUAL;
      k1_s1 <= 1'b1;
      k1_s2 <= 1'b1;
      k1_s3 <= 1'b1;
      k2_s1 <= 1'b1;
      k2_s2 <= 1'b1;
      k2_s3 <= 1'b1;
      ledr  <= '0;
      ledg  <= '0;
      hex0  <= SEG_BLANK;
      hex1  <= SEG_BLANK;
      hex2  <= SEG_TABLE[0];
      hex3  <= SEG_TABLE[0];
    end else begin
      k1_s1 <= key1_step;
      k1_s2 <= k1_s1;
      k1_s3 <= k1_s2;
      k2_s1 <= key2_auto;
      k2_s2 <= k2_s1;
      k2_s3 <= k2_s2;

      if (do_wr) begin
        wptr  <= wptr + AW'(1);
        count <= count + CW'(1);
      end

      // Step decisions see the count from before any same-cycle write.
      unique case (state)
        ST_MANUAL: begin
          if (has_data && auto_ev) begin
            state <= ST_AUTO;
            tick  <= '0;
          end else if (has_data && step_ev) begin
            rptr <= rptr_adv;
          end
        end
        ST_AUTO: begin
          if (auto_ev) begin
            state <= ST_MANUAL;
          end else if (tick_hit) begin
            tick <= '0;
            rptr <= rptr_adv;
            if (at_end && !sw8)
              state <= ST_MANUAL;
          end else begin
            tick <= tick + TW'(1);
          end
        end
      endcase

      ledr <= has_data ? rd : 8'h00;
      ledg <= therm;
      hex0 <= has_data ? seg_lo : SEG_BLANK;
      hex1 <= has_data ? seg_hi : SEG_BLANK;
      hex2 <= seg_ptr;
      hex3 <= seg_cnt;
    end
  end

endmodule

// File: tb/tb_task_4_playback.sv
// Scoreboard bench for task_4_playback: a queue-based model of the
// stored bytes predicts every display update, a monitor compares.
module tb_task_4_playback;

  localparam int TICK = 4;

  logic       clk = 1'b0;
  logic       key0_rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       key1_step;
  logic       key2_auto;
  logic       sw8;
  logic [7:0] ledr, ledg;
  logic [6:0] hex0, hex1, hex2, hex3;

  typedef struct packed {
    logic [7:0] ledr;
    logic [7:0] ledg;
    logic [6:0] h0;
    logic [6:0] h1;
    logic [6:0] h2;
    logic [6:0] h3;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] store[$];
  int   rp;
  bit   auto_m;
  int   phase;
  bit   h1[3];
  bit   h2[3];

  always #5 clk = ~clk;

  task_4_playback #(.DEPTH(8), .AW(3), .TICK_DIV(TICK)) dut (
    .clk(clk), .key0_rst(key0_rst),
    .wr_en(wr_en), .wr_data(wr_data),
    .key1_step(key1_step), .key2_auto(key2_auto), .sw8(sw8),
    .ledr(ledr), .ledg(ledg),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3)
  );

  function automatic logic [6:0] seg(input int n);
    case (n & 15)
      0: return 7'h40;   1: return 7'h79;
      2: return 7'h24;   3: return 7'h30;
      4: return 7'h19;   5: return 7'h12;
      6: return 7'h02;   7: return 7'h78;
      8: return 7'h00;   9: return 7'h10;
      10: return 7'h08;  11: return 7'h03;
      12: return 7'h46;  13: return 7'h21;
      14: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic exp_t view();
    exp_t e;
    int   n;
    n = store.size();
    e.ledr = (n > 0) ? store[rp] : 8'h00;
    e.h0   = (n > 0) ? seg(int'(store[rp][3:0])) : 7'h7F;
    e.h1   = (n > 0) ? seg(int'(store[rp][7:4])) : 7'h7F;
    e.h2   = seg(rp);
    e.h3   = seg(n);
    e.ledg = 8'((1 << n) - 1);
    return e;
  endfunction

  task automatic model_reset();
    store.delete();
    rp = 0;
    auto_m = 0;
    phase = 0;
    for (int i = 0; i < 3; i++) begin
      h1[i] = 1;
      h2[i] = 1;
    end
  endtask

  task automatic advance(input int n);
    if (rp < n - 1) rp++;
    else if (sw8) rp = 0;
    else auto_m = 0;
  endtask

  // One rising edge: outputs show the pre-edge picture, then rules apply.
  task automatic model_edge();
    int n;
    bit se, ae;
    n  = store.size();
    q.push_back(view());
    se = h1[2] && !h1[1];
    ae = h2[2] && !h2[1];
    if (!auto_m) begin
      if (n > 0 && ae) begin
        auto_m = 1;
        phase = 0;
      end else if (n > 0 && se) begin
        advance(n);
      end
    end else if (ae) begin
      auto_m = 0;
    end else begin
      phase++;
      if (phase == TICK) begin
        phase = 0;
        advance(n);
      end
    end
    if (wr_en && n < 8) store.push_back(wr_data);
    h1[2] = h1[1]; h1[1] = h1[0]; h1[0] = key1_step;
    h2[2] = h2[1]; h2[1] = h2[0]; h2[0] = key2_auto;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    key0_rst = 1'b0;
    q.delete();
    #2;
    chk("rst_ledr", ledr, 8'h00);
    chk("rst_ledg", ledg, 8'h00);
    chk("rst_hex0", {1'b0, hex0}, 8'h7F);
    chk("rst_hex1", {1'b0, hex1}, 8'h7F);
    chk("rst_hex2", {1'b0, hex2}, {1'b0, seg(0)});
    chk("rst_hex3", {1'b0, hex3}, {1'b0, seg(0)});
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    key0_rst = 1'b1;
  endtask

  task automatic write(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic press1();
    key1_step = 1'b0;
    repeat (3) cyc();
    key1_step = 1'b1;
    repeat (5) cyc();
  endtask

  task automatic press2();
    key2_auto = 1'b0;
    repeat (3) cyc();
    key2_auto = 1'b1;
    repeat (3) cyc();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (key0_rst && q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({ledr, ledg, hex0, hex1, hex2, hex3} !== e) begin
        errors++;
        $display("FAIL display t=%0t got ledr=%h ledg=%h hex=%h/%h/%h/%h want ledr=%h ledg=%h hex=%h/%h/%h/%h",
                 $time, ledr, ledg, hex0, hex1, hex2, hex3,
                 e.ledr, e.ledg, e.h0, e.h1, e.h2, e.h3);
      end
    end
  end

  initial begin
    key0_rst = 1'b1;
    wr_en = 1'b0;
    wr_data = 8'h00;
    key1_step = 1'b1;
    key2_auto = 1'b1;
    sw8 = 1'b0;
    model_reset();
    #1;
    do_reset();
    repeat (3) cyc();

    write(8'h06);
    write(8'hA5);
    repeat (2) cyc();
    chk("two_ledr", ledr, 8'h06);
    chk("two_ledg", ledg, 8'h03);
    chk("two_hex0", {1'b0, hex0}, {1'b0, seg(6)});
    chk("two_hex1", {1'b0, hex1}, {1'b0, seg(0)});
    chk("two_hex3", {1'b0, hex3}, {1'b0, seg(2)});

    sw8 = 1'b1;
    press1();
    chk("wrap1_ledr", ledr, 8'hA5);
    press1();
    chk("wrap2_ledr", ledr, 8'h06);
    sw8 = 1'b0;
    repeat (3) press1();
    chk("stop_ledr", ledr, 8'hA5);

    do_reset();
    for (int i = 0; i < 9; i++) write(8'(8'h10 + i));
    repeat (2) cyc();
    chk("full_ledg", ledg, 8'hFF);
    chk("full_hex3", {1'b0, hex3}, {1'b0, seg(8)});
    repeat (8) press1();
    chk("last_ledr", ledr, 8'h17);

    do_reset();
    write(8'h31);
    write(8'h32);
    write(8'h33);
    sw8 = 1'b0;
    press2();
    repeat (20) cyc();
    chk("auto_end", ledr, 8'h33);
    press2();
    repeat (12) cyc();

    sw8 = 1'b1;
    press2();
    repeat (6) cyc();
    key1_step = 1'b0;
    do_reset();
    repeat (6) cyc();
    key1_step = 1'b1;
    write(8'h44);
    write(8'h55);
    repeat (4) cyc();
    press1();
    chk("after_rst", ledr, 8'h55);

    do_reset();
    press1();
    press2();
    repeat (8) cyc();
    chk("empty_hex0", {1'b0, hex0}, 8'h7F);

    for (int c = 0; c < 600; c++) begin
      if (c % 150 == 149) do_reset();
      wr_en = ($urandom_range(0, 3) == 0);
      wr_data = 8'($urandom);
      if ($urandom_range(0, 5) == 0) key1_step = ~key1_step;
      if ($urandom_range(0, 7) == 0) key2_auto = ~key2_auto;
      if ($urandom_range(0, 39) == 0) sw8 = ~sw8;
      cyc();
    end
    wr_en = 1'b0;
    repeat (2) cyc();
    @(negedge clk);
    #1;
    chk("drain", 8'(q.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
